// File: rtl/lms_pkg.sv
// lms_pkg: shared state codes, widths and step saturation for the LMS adaptation controller
package lms_pkg;
  localparam int DATA_W = 8;
  localparam int STEP_W = 8;
  localparam int COEF_W = 20;
  typedef enum logic [2:0] {IDLE = 3'd0, CLEAR = 3'd1, TRAIN = 3'd2, TRACK = 3'd3, FREEZE = 3'd4} state_t;
  function automatic logic signed [STEP_W-1:0] sat8(input logic signed [15:0] v);
    return v > 16'sd127 ? 8'sd127 : v < -16'sd128 ? -8'sd128 : v[7:0];
  endfunction
endpackage

// File: rtl/lms_err_window.sv
// lms_err_window: windowed |err| accumulator with evaluation pulse and threshold compares
module lms_err_window #(
  parameter int WIN = 64,
  parameter int CONV_THR = 256,
  parameter int DIV_THR = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              add,
  input  logic signed [7:0] err,
  output logic              done,
  output logic              below,
  output logic              above
);
  localparam int CW = $clog2(WIN);
  localparam int AW = 9 + CW;
  logic [CW-1:0] cnt;
  logic [AW-1:0] acc, sum;
  logic [8:0] mag;
  assign mag = err[7] ? ~{err[7], err} + 9'd1 : {1'b0, err};
  // compares see the sum including the sample being accepted this cycle
  assign sum = acc + AW'(mag);
  assign done = add && cnt == CW'(WIN - 1);
  assign below = sum < AW'(CONV_THR);
  assign above = sum >= AW'(DIV_THR);
  always_ff @(posedge clk) begin
    if (rst || clr || done) begin
      cnt <= '0;
      acc <= '0;
    end else if (add) begin
      cnt <= cnt + CW'(1);
      acc <= sum;
    end
  end
endmodule

// File: rtl/lms_adapt_ctrl.sv
// lms_adapt_ctrl: LMS adaptation sequencer and step generator; define LMS_SIGN_ERR_EN for sign-error LMS
module lms_adapt_ctrl
  import lms_pkg::*;
#(
  parameter int MU_SHIFT = 4,
  parameter int TRACK_SHIFT = 2,
  parameter int WIN = 64,
  parameter int CONV_THR = 256,
  parameter int DIV_THR = 1024,
  parameter int CLR_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              freeze,
  input  logic signed [7:0] mu,
  input  logic              err_valid,
  input  logic signed [7:0] err_data,
  output logic              err_ready,
  output logic signed [7:0] step,
  output logic              upd_en,
  output logic              coef_clr,
  output logic [2:0]        state,
  output logic              converged
);
  localparam int ST = MU_SHIFT + TRACK_SHIFT;
  state_t st, nxt, from;
  logic [7:0] clr_cnt;
  logic act, hs, upd, done, below, above;
  logic signed [15:0] raw;
  assign act = st == TRAIN || st == TRACK;
  assign err_ready = act || st == FREEZE;
  assign hs = err_valid && err_ready;
  assign upd = hs && act && !start && !freeze;
  assign coef_clr = st == CLEAR;
  assign state = st;
`ifdef LMS_SIGN_ERR_EN
  logic signed [15:0] mus, m;
  assign mus = mu;
  assign m = st == TRACK ? mus >>> ST : mus >>> MU_SHIFT;
  assign raw = err_data == 8'sd0 ? 16'sd0 : err_data[7] ? -m : m;
`else
  logic signed [15:0] prod;
  assign prod = mu * err_data;
  assign raw = st == TRACK ? prod >>> ST : prod >>> MU_SHIFT;
`endif
  lms_err_window #(.WIN(WIN), .CONV_THR(CONV_THR), .DIV_THR(DIV_THR)) u_win (
    .clk  (clk),
    .rst  (rst),
    .clr  (start || freeze || !act),
    .add  (hs && act),
    .err  (err_data),
    .done (done),
    .below(below),
    .above(above)
  );
  always_comb begin
    nxt = st;
    if (start) nxt = CLEAR;
    else if (st == CLEAR) nxt = clr_cnt == 8'(CLR_CYCLES - 1) ? TRAIN : CLEAR;
    else if (act && freeze) nxt = FREEZE;
    else if (st == FREEZE) nxt = freeze ? FREEZE : from;
    else if (done && st == TRAIN && below) nxt = TRACK;
    else if (done && st == TRACK && above) nxt = TRAIN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      from <= TRAIN;
      clr_cnt <= '0;
      step <= '0;
      upd_en <= 1'b0;
      converged <= 1'b0;
    end else begin
      st <= nxt;
      clr_cnt <= st == CLEAR && !start ? clr_cnt + 8'd1 : 8'd0;
      step <= upd ? sat8(raw) : 8'sd0;
      upd_en <= upd;
      if (act && freeze) from <= st;
      converged <= start || st == CLEAR ? 1'b0 :
                   st == TRAIN && nxt == TRACK ? 1'b1 :
                   st == TRACK && nxt == TRAIN ? 1'b0 : converged;
    end
  end
endmodule

// File: tb/tb_lms_adapt_ctrl.sv
// tb_lms_adapt_ctrl: directed bench with a spec-level model checked every cycle plus literal checks
module tb_lms_adapt_ctrl;
  localparam int CLR_N = 2;
  localparam int WIN_N = 64;
  logic clk = 1'b0;
  logic rst, start, freeze, err_valid;
  logic signed [7:0] mu, err_data;
  logic err_ready, upd_en, coef_clr, converged;
  logic signed [7:0] step;
  logic [2:0] state;
  int n_tests = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  int m_st, m_step, m_upd, m_conv, m_cnt, m_sum, m_clrc, m_from;

  always #5 clk = ~clk;

  lms_adapt_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .freeze(freeze), .mu(mu),
    .err_valid(err_valid), .err_data(err_data), .err_ready(err_ready),
    .step(step), .upd_en(upd_en), .coef_clr(coef_clr), .state(state),
    .converged(converged)
  );

  function automatic int fdiv(input int p, input int s);
    int d;
    d = 1 << s;
    return p >= 0 ? p / d : -((-p + d - 1) / d);
  endfunction

  function automatic int clamp(input int v);
    return v > 127 ? 127 : v < -128 ? -128 : v;
  endfunction

  function automatic int model_step(input int mu_i, input int e, input int s);
`ifdef LMS_SIGN_ERR_EN
    int m;
    m = fdiv(mu_i, s);
    return e > 0 ? clamp(m) : e < 0 ? clamp(-m) : 0;
`else
    return clamp(fdiv(mu_i * e, s));
`endif
  endfunction

  always @(posedge clk) begin : model
    int e, a, ns;
    bit hs;
    if (rst) begin
      m_st = 0; m_step = 0; m_upd = 0; m_conv = 0;
      m_cnt = 0; m_sum = 0; m_clrc = 0; m_from = 2;
    end else begin
      e = err_data;
      a = e < 0 ? -e : e;
      hs = err_valid && m_st >= 2;
      ns = m_st;
      m_upd = 0;
      m_step = 0;
      if (start) begin
        ns = 1; m_clrc = 0; m_conv = 0; m_cnt = 0; m_sum = 0;
      end else if (m_st == 1) begin
        m_clrc++;
        if (m_clrc == CLR_N) ns = 2;
      end else if ((m_st == 2 || m_st == 3) && freeze) begin
        ns = 4; m_from = m_st; m_cnt = 0; m_sum = 0;
      end else if ((m_st == 2 || m_st == 3) && hs) begin
        m_upd = 1;
        m_step = model_step(mu, e, m_st == 3 ? 6 : 4);
        m_sum += a;
        m_cnt++;
        if (m_cnt == WIN_N) begin
          if (m_st == 2 && m_sum < 256) begin ns = 3; m_conv = 1; end
          else if (m_st == 3 && m_sum >= 1024) begin ns = 2; m_conv = 0; end
          m_cnt = 0;
          m_sum = 0;
        end
      end else if (m_st == 4) begin
        m_cnt = 0; m_sum = 0;
        if (!freeze) ns = m_from;
      end
      m_st = ns;
    end
  end

  task automatic chk(input string nm, input logic signed [15:0] act, input int exp);
    n_tests++;
    if (act !== 16'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_state", state, m_st);
      chk("m_step", step, m_step);
      chk("m_upd_en", upd_en, m_upd);
      chk("m_converged", converged, m_conv);
      chk("m_err_ready", err_ready, int'(m_st >= 2));
      chk("m_coef_clr", coef_clr, int'(m_st == 1));
    end
  end

  task automatic cyc(input bit s, input bit f, input int m, input bit v, input int e);
    start = s; freeze = f; mu = 8'(m); err_valid = v; err_data = 8'(e);
    @(posedge clk);
    #1;
  endtask

  task automatic samples(input int n, input int m, input int e);
    repeat (n) cyc(0, 0, m, 1, e);
  endtask

  initial begin
    rst = 1; start = 0; freeze = 0; mu = 0; err_valid = 0; err_data = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1;
    chk("rst_state", state, 0);
    chk("rst_ready", err_ready, 0);
    rst = 0;
    cyc(1, 0, 0, 0, 0);
    chk("clr_cycle1", coef_clr, 1);
    cyc(0, 0, 0, 0, 0);
    chk("clr_cycle2", coef_clr, 1);
    cyc(0, 0, 0, 0, 0);
    chk("train_state", state, 2);
    chk("train_clr_low", coef_clr, 0);
    chk("train_ready", err_ready, 1);
    cyc(0, 0, 16, 1, -8);
    chk("upd_pulse", upd_en, 1);
`ifndef LMS_SIGN_ERR_EN
    chk("step_m8", step, -8);
`endif
    cyc(0, 0, 0, 0, 0);
    chk("upd_drop", upd_en, 0);
    chk("step_idle", step, 0);
    cyc(0, 0, 64, 1, 32);
`ifndef LMS_SIGN_ERR_EN
    chk("step_sat_hi", step, 127);
    cyc(0, 0, 1, 1, -1);
    chk("step_floor", step, -1);
    cyc(0, 0, 127, 1, -128);
    chk("step_sat_lo", step, -128);
    cyc(0, 0, -128, 1, -128);
    chk("step_negneg", step, 127);
`endif
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    samples(WIN_N - 1, 16, 3);
    chk("conv_pre_state", state, 2);
    chk("conv_pre_flag", converged, 0);
    cyc(0, 0, 16, 1, 3);
    chk("conv_state", state, 3);
    chk("conv_flag", converged, 1);
    cyc(0, 0, 64, 1, 32);
`ifndef LMS_SIGN_ERR_EN
    chk("track_step", step, 32);
`endif
    samples(WIN_N - 2, 16, -20);
    chk("div_pre_state", state, 3);
    cyc(0, 0, 16, 1, -20);
    chk("div_state", state, 2);
    chk("div_flag", converged, 0);
    samples(10, 16, 5);
    cyc(0, 1, 16, 1, 50);
    chk("frz_state", state, 4);
    chk("frz_ready", err_ready, 1);
    chk("frz_upd", upd_en, 0);
    chk("frz_step", step, 0);
    repeat (4) cyc(0, 1, 16, 1, 50);
    cyc(0, 0, 16, 0, 0);
    chk("unfrz_state", state, 2);
    samples(WIN_N - 1, 16, 1);
    chk("win_restart_pre", state, 2);
    cyc(0, 0, 16, 1, 1);
    chk("win_restart_conv", state, 3);
    cyc(0, 1, 16, 1, 9);
    chk("frz_track", state, 4);
    cyc(0, 0, 16, 0, 0);
    chk("unfrz_track", state, 3);
    chk("unfrz_conv", converged, 1);
    cyc(1, 0, 16, 1, 50);
    chk("start_drop_upd", upd_en, 0);
    chk("start_clear", state, 1);
    chk("start_conv_clr", converged, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 16, 1, 50);
    chk("pre_rst_upd", upd_en, 1);
    rst = 1;
    cyc(0, 0, 16, 1, 50);
    cyc(0, 0, 16, 1, 50);
    chk("rst2_state", state, 0);
    chk("rst2_step", step, 0);
    chk("rst2_upd", upd_en, 0);
    chk("rst2_ready", err_ready, 0);
    chk("rst2_conv", converged, 0);
    rst = 0;
    cyc(0, 0, 0, 0, 0);
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
